// File: rtl/exc_ctrl.sv
`timescale 1ns/1ps
// exc_ctrl: arbitrates interrupt / exception / ertn at writeback, pulses the
// CSR commit, holds a timed pipeline flush, then hands a redirect PC to fetch.
// Ports:
//   ws_*            writeback instruction and its exception information
//   int_*           pending interrupt and global interrupt enable from CSRs
//   eentry/era      exception entry and return addresses from CSRs
//   ev_ready        high while idle and able to accept an event
//   csr_wb_*        one-cycle exception/interrupt commit to the CSR file
//   csr_ertn        one-cycle ertn commit to the CSR file
//   flush           pipeline flush, FLUSH_CYCLES cycles long
//   redirect_*      valid/ready redirect to fetch
// Optional: define EXC_CTRL_STAT_EN to add saturating event counters
// (stat_clr, stat_exc_cnt, stat_int_cnt, stat_ertn_cnt).
module exc_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [5:0]  ECODE_INT    = 6'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    input  logic        ws_ex,
    input  logic [5:0]  ws_ecode,
    input  logic [8:0]  ws_esubcode,
    input  logic [31:0] ws_pc,
    input  logic [31:0] ws_badvaddr,
    input  logic        ws_ertn,
    input  logic        int_pending,
    input  logic        int_enable,
    input  logic [31:0] eentry_addr,
    input  logic [31:0] era_addr,
    output logic        ev_ready,
    output logic        csr_wb_ex,
    output logic [5:0]  csr_wb_ecode,
    output logic [8:0]  csr_wb_esubcode,
    output logic [31:0] csr_wb_pc,
    output logic [31:0] csr_wb_badvaddr,
    output logic        csr_ertn,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
`ifdef EXC_CTRL_STAT_EN
    input  logic        stat_clr,
    output logic [15:0] stat_exc_cnt,
    output logic [15:0] stat_int_cnt,
    output logic [15:0] stat_ertn_cnt,
`endif
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        S_IDLE, S_COMMIT, S_FLUSH, S_REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        K_NONE, K_EXC, K_INT, K_ERTN
    } kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ev_ready_q, ev_ready_d;
    logic        wb_ex_q, wb_ex_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] badv_q, badv_d;
    logic        ertn_q, ertn_d;
    logic        flush_q, flush_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rpc_q, rpc_d;
    logic [31:0] target;

    // Redirect target is sampled after the CSR commit edge, so ERA/EENTRY
    // already reflect the committed event.
    assign target = (kind_q == K_ERTN) ? era_addr : eentry_addr;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        wb_ex_d = 1'b0;
        ecode_d = 6'h00;
        esub_d  = 9'h000;
        pc_d    = 32'h0;
        badv_d  = 32'h0;
        ertn_d  = 1'b0;
        rpc_d   = rpc_q;
        unique case (state_q)
            S_IDLE: begin
                if (ws_valid) begin
                    if (int_pending && int_enable) begin
                        state_d = S_COMMIT;
                        kind_d  = K_INT;
                        wb_ex_d = 1'b1;
                        ecode_d = ECODE_INT;
                        pc_d    = ws_pc;
                    end else if (ws_ex) begin
                        state_d = S_COMMIT;
                        kind_d  = K_EXC;
                        wb_ex_d = 1'b1;
                        ecode_d = ws_ecode;
                        esub_d  = ws_esubcode;
                        pc_d    = ws_pc;
                        badv_d  = ws_badvaddr;
                    end else if (ws_ertn) begin
                        state_d = S_COMMIT;
                        kind_d  = K_ERTN;
                        ertn_d  = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                if (FLUSH_CYCLES <= 1) begin
                    state_d = S_REDIRECT;
                    rpc_d   = target;
                end else begin
                    state_d = S_FLUSH;
                    cnt_d   = 4'(FLUSH_CYCLES - 1);
                end
            end
            S_FLUSH: begin
                // Leave on the edge where the counter reaches zero; FLUSH
                // therefore lasts FLUSH_CYCLES-1 cycles after COMMIT.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_REDIRECT;
                    rpc_d   = target;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = S_IDLE;
                    kind_d  = K_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ev_ready_d = (state_d == S_IDLE);
        flush_d    = (state_d == S_COMMIT) || (state_d == S_FLUSH);
        rvalid_d   = (state_d == S_REDIRECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            kind_q     <= K_NONE;
            cnt_q      <= 4'd0;
            ev_ready_q <= 1'b1;
            wb_ex_q    <= 1'b0;
            ecode_q    <= 6'h00;
            esub_q     <= 9'h000;
            pc_q       <= 32'h0;
            badv_q     <= 32'h0;
            ertn_q     <= 1'b0;
            flush_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rpc_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            ev_ready_q <= ev_ready_d;
            wb_ex_q    <= wb_ex_d;
            ecode_q    <= ecode_d;
            esub_q     <= esub_d;
            pc_q       <= pc_d;
            badv_q     <= badv_d;
            ertn_q     <= ertn_d;
            flush_q    <= flush_d;
            rvalid_q   <= rvalid_d;
            rpc_q      <= rpc_d;
        end
    end

    assign ev_ready        = ev_ready_q;
    assign csr_wb_ex       = wb_ex_q;
    assign csr_wb_ecode    = ecode_q;
    assign csr_wb_esubcode = esub_q;
    assign csr_wb_pc       = pc_q;
    assign csr_wb_badvaddr = badv_q;
    assign csr_ertn        = ertn_q;
    assign flush           = flush_q;
    assign redirect_valid  = rvalid_q;
    assign redirect_pc     = rpc_q;

`ifdef EXC_CTRL_STAT_EN
    logic [15:0] exc_cnt_q, int_cnt_q, ertn_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_cnt_q  <= 16'h0;
            int_cnt_q  <= 16'h0;
            ertn_cnt_q <= 16'h0;
        end else if (stat_clr) begin
            exc_cnt_q  <= 16'h0;
            int_cnt_q  <= 16'h0;
            ertn_cnt_q <= 16'h0;
        end else if (state_q == S_COMMIT) begin
            if (kind_q == K_EXC && exc_cnt_q != 16'hFFFF)
                exc_cnt_q <= exc_cnt_q + 16'd1;
            if (kind_q == K_INT && int_cnt_q != 16'hFFFF)
                int_cnt_q <= int_cnt_q + 16'd1;
            if (kind_q == K_ERTN && ertn_cnt_q != 16'hFFFF)
                ertn_cnt_q <= ertn_cnt_q + 16'd1;
        end
    end

    assign stat_exc_cnt  = exc_cnt_q;
    assign stat_int_cnt  = int_cnt_q;
    assign stat_ertn_cnt = ertn_cnt_q;
`endif

endmodule
